pool_window_ctrl: RTL and testbench

Sequencer for the 3x3 max-pooling datapath. It scans an H x W feature map with a configurable stride and emits one window descriptor per output pixel: centre row/col plus the 9-bit tap-select mask that drives the pooling unit's inX_sel. Taps that fall in the implicit padding border are masked out. The block sits between the layer-control start/done interface and the line-buffer/pooling datapath, which consumes descriptors through a valid/ready handshake.

---
 rtl/pool_window_ctrl_if.sv | 32 +++
 rtl/pool_window_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pool_window_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_window_ctrl_if.sv
// Window descriptor bus between the pooling sequencer (master) and the
// line-buffer/pooling datapath (slave). Plain valid/ready handshake.
interface pool_window_ctrl_if #(
  parameter int unsigned DIM_W = 6
) ();

  logic             win_valid;
  logic             win_ready;
  logic [DIM_W-1:0] win_row;
  logic [DIM_W-1:0] win_col;
  logic [8:0]       win_sel;
  logic             win_last;

  modport master (
    output win_valid,
    output win_row,
    output win_col,
    output win_sel,
    output win_last,
    input  win_ready
  );

  modport slave (
    input  win_valid,
    input  win_row,
    input  win_col,
    input  win_sel,
    input  win_last,
    output win_ready
  );

endinterface

// File: rtl/pool_window_ctrl.sv
// 3x3 max-pool window sequencer. Scans an H x W map with stride 1 or 2 and
// emits one descriptor (centre row/col, 9-bit tap mask, last flag) per output
// pixel. Taps that land in the padding border are cleared in the mask.
// Optional macro POOL_CTRL_PERF_EN adds a saturating backpressure counter;
// without it o_stall_cnt is tied to zero.
module pool_window_ctrl #(
  parameter int unsigned DIM_W = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [DIM_W-1:0]   i_cfg_height,
  input  logic [DIM_W-1:0]   i_cfg_width,
  input  logic               i_cfg_stride2,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [15:0]        o_stall_cnt,
  pool_window_ctrl_if.master io_win
);

  localparam int unsigned DW1 = DIM_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [DIM_W-1:0] r_h;
  logic [DIM_W-1:0] r_w;
  logic [DIM_W-1:0] r_row;
  logic [DIM_W-1:0] r_col;
  logic             r_s2;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_valid;

  // Widened by one bit so row+S / col+S / edge checks never wrap.
  logic [DIM_W:0]   w_step;
  logic [DIM_W:0]   w_h;
  logic [DIM_W:0]   w_w;
  logic [DIM_W:0]   w_row;
  logic [DIM_W:0]   w_col;
  logic [DIM_W:0]   w_row_nx;
  logic [DIM_W:0]   w_col_nx;
  logic             w_row_end;
  logic             w_col_end;
  logic             w_last;
  logic             w_hs;
  logic [2:0]       w_row_ok;
  logic [2:0]       w_col_ok;
  logic [8:0]       w_sel;

  // Scan geometry, edge tests and tap mask, all from registered state.
  always_comb begin
    w_step    = r_s2 ? DW1'(2) : DW1'(1);
    w_h       = {1'b0, r_h};
    w_w       = {1'b0, r_w};
    w_row     = {1'b0, r_row};
    w_col     = {1'b0, r_col};
    w_row_nx  = w_row + w_step;
    w_col_nx  = w_col + w_step;
    w_row_end = (w_row_nx >= w_h);
    w_col_end = (w_col_nx >= w_w);
    w_last    = w_row_end && w_col_end;
    w_hs      = r_valid && io_win.win_ready;
    // Index 0/1/2 correspond to offset -1/0/+1; "+1 in range" is pos+2 <= dim.
    w_row_ok[0] = (w_row != '0);
    w_row_ok[1] = (w_row < w_h);
    w_row_ok[2] = ((w_row + DW1'(2)) <= w_h);
    w_col_ok[0] = (w_col != '0);
    w_col_ok[1] = (w_col < w_w);
    w_col_ok[2] = ((w_col + DW1'(2)) <= w_w);
    w_sel = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        w_sel[dr*3+dc] = (r_state == StRun) && w_row_ok[dr] && w_col_ok[dc];
      end
    end
  end

  // Control FSM with registered status and valid outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
      r_h     <= '0;
      r_w     <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_s2    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_h   <= i_cfg_height;
            r_w   <= i_cfg_width;
            r_s2  <= i_cfg_stride2;
            r_row <= '0;
            r_col <= '0;
            r_busy <= 1'b1;
            if ((i_cfg_height == '0) || (i_cfg_width == '0)) begin
              // Empty map: skip RUN, report completion with error.
              r_state <= StDone;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state <= StRun;
              r_valid <= 1'b1;
            end
          end
        end
        StRun: begin
          if (w_hs) begin
            if (w_last) begin
              r_state <= StDone;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_col_end) begin
              r_col <= '0;
              r_row <= w_row_nx[DIM_W-1:0];
            end else begin
              r_col <= w_col_nx[DIM_W-1:0];
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign io_win.win_valid = r_valid;
  assign io_win.win_row   = r_row;
  assign io_win.win_col   = r_col;
  assign io_win.win_sel   = w_sel;
  assign io_win.win_last  = (r_state == StRun) && w_last;

`ifdef POOL_CTRL_PERF_EN
  logic [15:0] r_stall_cnt;

  // Count presented-but-not-accepted cycles; saturate, clear on a new scan.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == StIdle) && i_start) begin
      r_stall_cnt <= '0;
    end else if (r_valid && !io_win.win_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pool_window_ctrl.sv
// Self-checking bench for pool_window_ctrl: table of directed scans, a few
// hand-written corner sequences, and randomized scans against a reference
// model that enumerates windows directly from the scan rules.
module tb_pool_window_ctrl;

  localparam int unsigned DIM_W = 6;

  logic             clk;
  logic             reset;
  logic             start;
  logic [DIM_W-1:0] cfg_h;
  logic [DIM_W-1:0] cfg_w;
  logic             cfg_s2;
  logic             busy;
  logic             done;
  logic             err;
  logic [15:0]      stall_cnt;

  pool_window_ctrl_if #(.DIM_W(DIM_W)) u_if ();

  pool_window_ctrl #(.DIM_W(DIM_W)) u_dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start),
    .i_cfg_height  (cfg_h),
    .i_cfg_width   (cfg_w),
    .i_cfg_stride2 (cfg_s2),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .o_stall_cnt   (stall_cnt),
    .io_win        (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Observations from the most recent scan.
  int obs_n;
  int obs_first_sel;
  int obs_last_row;
  int obs_last_col;
  int obs_last_sel;
  int obs_stall;

  typedef struct {
    int h;
    int w;
    int s2;
    int cnt;
    int first_sel;
    int last_row;
    int last_col;
    int last_sel;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tap mask straight from the padding rule.
  function automatic int ref_sel(input int h, input int w, input int r, input int c);
    int m;
    m = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((r + dr >= 0) && (r + dr < h) && (c + dc >= 0) && (c + dc < w)) begin
          m = m | (1 << ((dr + 1) * 3 + (dc + 1)));
        end
      end
    end
    return m;
  endfunction

  // mode 0: always ready, 1: random ready, 2: hold ready low 5 cycles at window 2.
  task automatic do_scan(input int h, input int w, input int s2, input int mode, input int inj);
    int s;
    int n;
    int idx;
    int stalls;
    int cyc;
    int hold;
    int exp_stall;
    bit rdy;
    int er[$];
    int ec[$];
    int es[$];
    s = (s2 != 0) ? 2 : 1;
    for (int r = 0; r < h; r += s) begin
      for (int c = 0; c < w; c += s) begin
        er.push_back(r);
        ec.push_back(c);
        es.push_back(ref_sel(h, w, r, c));
      end
    end
    n = er.size();
    obs_n = 0;
    obs_first_sel = -1;
    obs_last_row = -1;
    obs_last_col = -1;
    obs_last_sel = -1;
    obs_stall = -1;
    start  = 1'b1;
    cfg_h  = 6'(h);
    cfg_w  = 6'(w);
    cfg_s2 = (s2 != 0);
    step();
    start  = 1'b0;
    // Mid-scan configuration changes must not matter.
    cfg_h  = 6'($urandom_range(0, 63));
    cfg_w  = 6'($urandom_range(0, 63));
    cfg_s2 = 1'($urandom_range(0, 1));
    idx = 0;
    stalls = 0;
    cyc = 0;
    hold = 0;
    while (idx < n) begin
      if (cyc >= 3000) begin
        n_chk++;
        n_fail++;
        $display("FAIL scan_timeout: got idx %0d expected %0d windows", idx, n);
        break;
      end
      check("win_valid", u_if.win_valid, 1);
      check("win_row", u_if.win_row, er[idx]);
      check("win_col", u_if.win_col, ec[idx]);
      check("win_sel", u_if.win_sel, es[idx]);
      check("win_last", u_if.win_last, (idx == n - 1) ? 1 : 0);
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          if (idx == 2 && hold < 5) begin
            rdy = 1'b0;
            hold++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      if (inj != 0 && idx == 1) begin
        start = 1'b1;
        cfg_h = 6'd1;
        cfg_w = 6'd1;
      end else begin
        start = 1'b0;
      end
      u_if.win_ready = rdy;
      if (!rdy) stalls++;
      if (u_if.win_valid && rdy) begin
        obs_n++;
        if (obs_n == 1) obs_first_sel = int'(u_if.win_sel);
        if (u_if.win_last) begin
          obs_last_row = int'(u_if.win_row);
          obs_last_col = int'(u_if.win_col);
          obs_last_sel = int'(u_if.win_sel);
        end
      end
      step();
      cyc++;
      if (rdy) idx++;
    end
    start = 1'b0;
    u_if.win_ready = 1'($urandom_range(0, 1));
    if (idx == n) begin
`ifdef POOL_CTRL_PERF_EN
      exp_stall = stalls;
`else
      exp_stall = 0;
`endif
      check("done_pulse", done, 1);
      check("err_clean", err, 0);
      check("busy_done", busy, 1);
      check("valid_done", u_if.win_valid, 0);
      check("sel_done", u_if.win_sel, 0);
      check("last_done", u_if.win_last, 0);
      check("stall_cnt", stall_cnt, exp_stall);
      obs_stall = int'(stall_cnt);
      step();
      check("busy_idle", busy, 0);
      check("done_idle", done, 0);
      check("valid_idle", u_if.win_valid, 0);
    end
  endtask

  task automatic do_err(input int h, input int w);
    start  = 1'b1;
    cfg_h  = 6'(h);
    cfg_w  = 6'(w);
    cfg_s2 = 1'($urandom_range(0, 1));
    step();
    start = 1'b0;
    check("err_done", done, 1);
    check("err_err", err, 1);
    check("err_busy", busy, 1);
    check("err_valid", u_if.win_valid, 0);
    step();
    check("err_done_clr", done, 0);
    check("err_err_clr", err, 0);
    check("err_busy_clr", busy, 0);
    check("err_valid_idle", u_if.win_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_plan_stall;
    vecs[0] = '{h: 3, w: 3, s2: 0, cnt: 9,  first_sel: 'h1B0, last_row: 2, last_col: 2, last_sel: 'h01B};
    vecs[1] = '{h: 4, w: 4, s2: 1, cnt: 4,  first_sel: 'h1B0, last_row: 2, last_col: 2, last_sel: 'h1FF};
    vecs[2] = '{h: 1, w: 1, s2: 0, cnt: 1,  first_sel: 'h010, last_row: 0, last_col: 0, last_sel: 'h010};
    vecs[3] = '{h: 5, w: 3, s2: 1, cnt: 6,  first_sel: 'h1B0, last_row: 4, last_col: 2, last_sel: 'h01B};
    vecs[4] = '{h: 2, w: 5, s2: 0, cnt: 10, first_sel: 'h1B0, last_row: 1, last_col: 4, last_sel: 'h01B};
    vecs[5] = '{h: 3, w: 1, s2: 0, cnt: 3,  first_sel: 'h090, last_row: 2, last_col: 0, last_sel: 'h012};

    reset = 1'b0;
    start = 1'b0;
    cfg_h = '0;
    cfg_w = '0;
    cfg_s2 = 1'b0;
    u_if.win_ready = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_valid", u_if.win_valid, 0);
    check("rst_sel", u_if.win_sel, 0);
    check("rst_last", u_if.win_last, 0);
    check("rst_stall", stall_cnt, 0);
    reset = 1'b1;
    step();

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      do_scan(vecs[i].h, vecs[i].w, vecs[i].s2, 0, 0);
      check("tbl_count", obs_n, vecs[i].cnt);
      check("tbl_first_sel", obs_first_sel, vecs[i].first_sel);
      check("tbl_last_row", obs_last_row, vecs[i].last_row);
      check("tbl_last_col", obs_last_col, vecs[i].last_col);
      check("tbl_last_sel", obs_last_sel, vecs[i].last_sel);
    end

    // Backpressure on window (0,2) for five cycles.
    do_scan(3, 3, 0, 2, 0);
`ifdef POOL_CTRL_PERF_EN
    exp_plan_stall = 5;
`else
    exp_plan_stall = 0;
`endif
    check("plan_stall", obs_stall, exp_plan_stall);
    check("plan_stall_cnt", obs_n, 9);

    // Empty maps.
    do_err(0, 5);
    do_err(5, 0);

    // start while busy is ignored.
    do_scan(3, 3, 0, 1, 1);
    check("busy_start_count", obs_n, 9);

    // Async reset in the middle of window 4.
    start  = 1'b1;
    cfg_h  = 6'd3;
    cfg_w  = 6'd3;
    cfg_s2 = 1'b0;
    u_if.win_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("pre_rst_row", u_if.win_row, 1);
    check("pre_rst_col", u_if.win_col, 0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", u_if.win_valid, 0);
    check("arst_row", u_if.win_row, 0);
    check("arst_col", u_if.win_col, 0);
    check("arst_sel", u_if.win_sel, 0);
    check("arst_last", u_if.win_last, 0);
    check("arst_done", done, 0);
    check("arst_stall", stall_cnt, 0);
    step();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_valid", u_if.win_valid, 0);
      check("post_rst_busy", busy, 0);
    end
    do_scan(3, 3, 0, 0, 0);
    check("post_rst_first", obs_first_sel, 'h1B0);

    // Randomized scans against the model.
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_err(0, $urandom_range(0, 12));
      end else begin
        do_scan($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(0, 1), 1,
                $urandom_range(0, 1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
